// File: rtl/ksa4_word_scheduler.sv
// Round-robin word scheduler that drives one shared 4-bit KSA adder nibble by nibble, LSB first.
// Optional KSA4_WARMUP_EN adds a post-reset WARMUP state that keeps the adder idle for WARMUP_CYC cycles.
module ksa4_word_scheduler #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned KSA_LAT = 4
`ifdef KSA4_WARMUP_EN
    ,
    parameter int unsigned WARMUP_CYC = 20
`endif
) (
    input  logic                   GCLK_Pad,
    input  logic                   RST_Pad,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   ksa_issue,
    output logic [3:0]             ksa_a,
    output logic [3:0]             ksa_b,
    output logic                   ksa_cin,
    input  logic [3:0]             ksa_sum,
    input  logic                   ksa_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned LAT_W = (KSA_LAT > 1) ? $clog2(KSA_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3
`ifdef KSA4_WARMUP_EN
        ,
        S_WARMUP = 3'd4
`endif
    } state_t;

`ifdef KSA4_WARMUP_EN
    localparam state_t      RESET_STATE = S_WARMUP;
    localparam int unsigned WARM_W      = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    logic [WARM_W-1:0] warm_q, warm_d;
`else
    localparam state_t      RESET_STATE = S_IDLE;
`endif

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   nib_q, nib_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       acc_q, acc_d;
    logic               id_q, id_d;
    logic               carry_q, carry_d;
    logic               prio_q, prio_d;

    logic               ksa_issue_d;
    logic [3:0]         ksa_a_d, ksa_b_d;
    logic               ksa_cin_d;
    logic               rsp_valid_d, rsp_id_d, rsp_cout_d;
    logic [W-1:0]       rsp_sum_d;

    logic               grant0_c, grant1_c;

    // Extract nibble n of a word, nibble 0 being the least significant.
    function automatic logic [3:0] nib_sel(input logic [W-1:0] v, input logic [NIB_W-1:0] n);
        return 4'(v >> {n, 2'b00});
    endfunction

    // Round-robin: prio names the favoured requester when both are valid.
    assign grant0_c   = req0_valid & (~req1_valid | ~prio_q);
    assign grant1_c   = req1_valid & ~grant0_c;
    assign req0_ready = (state_q == S_IDLE) & grant0_c;
    assign req1_ready = (state_q == S_IDLE) & grant1_c;

    always_comb begin
        state_d     = state_q;
        nib_d       = nib_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        id_d        = id_q;
        carry_d     = carry_q;
        prio_d      = prio_q;
        ksa_issue_d = 1'b0;
        ksa_a_d     = 4'd0;
        ksa_b_d     = 4'd0;
        ksa_cin_d   = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_sum_d   = rsp_sum;
        rsp_cout_d  = rsp_cout;
`ifdef KSA4_WARMUP_EN
        warm_d      = warm_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (grant0_c || grant1_c) begin
                    a_d         = grant1_c ? req1_a : req0_a;
                    b_d         = grant1_c ? req1_b : req0_b;
                    carry_d     = grant1_c ? req1_cin : req0_cin;
                    id_d        = grant1_c;
                    nib_d       = '0;
                    state_d     = S_ISSUE;
                    // KSA inputs are registered, so the first nibble is staged on accept.
                    ksa_issue_d = 1'b1;
                    ksa_a_d     = nib_sel(a_d, '0);
                    ksa_b_d     = nib_sel(b_d, '0);
                    ksa_cin_d   = carry_d;
                end
            end

            S_ISSUE: begin
                cnt_d   = LAT_W'(KSA_LAT - 1);
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    for (int unsigned i = 0; i < NIBBLES; i++) begin
                        if (nib_q == NIB_W'(i)) begin
                            acc_d[4*i +: 4] = ksa_sum;
                        end
                    end
                    carry_d = ksa_cout;
                    if (nib_q == NIB_W'(NIBBLES - 1)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = id_q;
                        rsp_sum_d   = acc_d;
                        rsp_cout_d  = ksa_cout;
                    end else begin
                        nib_d       = nib_q + NIB_W'(1);
                        state_d     = S_ISSUE;
                        ksa_issue_d = 1'b1;
                        ksa_a_d     = nib_sel(a_q, nib_d);
                        ksa_b_d     = nib_sel(b_q, nib_d);
                        ksa_cin_d   = ksa_cout;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    prio_d      = ~rsp_id;
                    state_d     = S_IDLE;
                end
            end

`ifdef KSA4_WARMUP_EN
            S_WARMUP: begin
                if (warm_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    warm_d = warm_q - WARM_W'(1);
                end
            end
`endif

            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge GCLK_Pad) begin
        if (RST_Pad) begin
            state_q   <= RESET_STATE;
            nib_q     <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            id_q      <= 1'b0;
            carry_q   <= 1'b0;
            prio_q    <= 1'b0;
            ksa_issue <= 1'b0;
            ksa_a     <= 4'd0;
            ksa_b     <= 4'd0;
            ksa_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifdef KSA4_WARMUP_EN
            warm_q    <= WARM_W'(WARMUP_CYC - 1);
`endif
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            id_q      <= id_d;
            carry_q   <= carry_d;
            prio_q    <= prio_d;
            ksa_issue <= ksa_issue_d;
            ksa_a     <= ksa_a_d;
            ksa_b     <= ksa_b_d;
            ksa_cin   <= ksa_cin_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_sum   <= rsp_sum_d;
            rsp_cout  <= rsp_cout_d;
`ifdef KSA4_WARMUP_EN
            warm_q    <= warm_d;
`endif
        end
    end

endmodule

// File: tb/tb_ksa4_word_scheduler.sv
// Scoreboard bench for ksa4_word_scheduler with a delayed return-to-zero adder model.
// Build with KSA4_WARMUP_EN defined to also cover the post-reset warm-up window.
module tb_ksa4_word_scheduler;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned KSA_LAT = 4;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam int          LATENCY = NIBBLES * (1 + KSA_LAT);
`ifdef KSA4_WARMUP_EN
    localparam int          FIRST_WAIT = 20;
`else
    localparam int          FIRST_WAIT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic         ksa_issue, ksa_cin, ksa_cout;
    logic [3:0]   ksa_a, ksa_b, ksa_sum;
    logic         rsp_valid, rsp_id, rsp_cout;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;

    ksa4_word_scheduler #(.NIBBLES(NIBBLES), .KSA_LAT(KSA_LAT)) dut (
        .GCLK_Pad(clk), .RST_Pad(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .ksa_issue(ksa_issue), .ksa_a(ksa_a), .ksa_b(ksa_b), .ksa_cin(ksa_cin),
        .ksa_sum(ksa_sum), .ksa_cout(ksa_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    // Adder model: result of the inputs appears KSA_LAT cycles later; zero inputs give zero output.
    logic [4:0] pipe [KSA_LAT];
    always @(posedge clk) begin
        pipe[0] <= 5'(ksa_a) + 5'(ksa_b) + 5'(ksa_cin);
        for (int i = 1; i < KSA_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ksa_sum  = pipe[KSA_LAT-1][3:0];
    assign ksa_cout = pipe[KSA_LAT-1][4];

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        int           acc_cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0, n_err = 0, cyc = 0;
    bit           in_reset = 1'b1, model_prio = 1'b0, in_rsp = 1'b0;
    int           stall_next = 0, hold_cnt = 0, wait_n = 0;
    logic [W+1:0] held;
    logic [W-1:0] cur_a = '0, cur_b = '0;
    logic         cur_c = 1'b0;
    int           issue_idx = NIBBLES, last_issue_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [W-1:0] v, input int k);
        return 4'(v >> (4 * k));
    endfunction

    // Carry into nibble k is the overflow of the low 4k bits of a+b+cin.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int k);
        logic [31:0] m, s;
        m = (32'd1 << (4 * k)) - 32'd1;
        s = (32'(a) & m) + (32'(b) & m) + 32'(c);
        return s[4*k];
    endfunction

    // Adder-side watcher: each issued nibble and its carry must follow the word arithmetic.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (ksa_issue) begin
                chk("issue_count", 32'(issue_idx < int'(NIBBLES)), 32'd1);
                if (issue_idx < int'(NIBBLES)) begin
                    chk("issue_a", 32'(ksa_a), 32'(nib_of(cur_a, issue_idx)));
                    chk("issue_b", 32'(ksa_b), 32'(nib_of(cur_b, issue_idx)));
                    chk("issue_cin", 32'(ksa_cin), 32'(carry_into(cur_a, cur_b, cur_c, issue_idx)));
                    if (issue_idx > 0) chk("issue_gap", 32'(cyc - last_issue_cyc), 32'(1 + KSA_LAT));
                end
                last_issue_cyc = cyc;
                issue_idx++;
            end else begin
                chk("ksa_rtz", 32'({ksa_a, ksa_b, ksa_cin}), 32'd0);
            end
        end
    end

    // Response monitor: pops the scoreboard on each handshake, applies back-pressure.
    always @(negedge clk) begin
        exp_t e;
        if (in_reset) begin
            rsp_ready = 1'b0;
            in_rsp    = 1'b0;
        end else if (rsp_valid) begin
            chk("resp_quiet", 32'({req0_ready, req1_ready, ksa_issue}), 32'd0);
            if (!in_rsp) begin
                in_rsp   = 1'b1;
                hold_cnt = 0;
                wait_n   = stall_next;
                held     = {rsp_id, rsp_sum, rsp_cout};
                if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(LATENCY));
            end else begin
                chk("rsp_hold", 32'({rsp_id, rsp_sum, rsp_cout}), 32'(held));
            end
            if (hold_cnt >= wait_n) begin
                rsp_ready = 1'b1;
                in_rsp    = 1'b0;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                    model_prio = ~e.id;
                end
                stall_next = int'($urandom_range(0, 2));
            end else begin
                rsp_ready = 1'b0;
                hold_cnt++;
            end
        end else begin
            rsp_ready = 1'b0;
        end
    end

    task automatic accept_req(input bit v0, input bit v1,
                              input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                              output int w, output int n_wait);
        bit           ok;
        logic [W:0]   full;
        exp_t         e;
        ok = 1'b0; w = 0; n_wait = 0;
        @(posedge clk); #1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            n_wait++;
            if (req0_ready || req1_ready) begin
                w = (v0 && v1) ? int'(model_prio) : (v1 ? 1 : 0);
                chk("grant", 32'({req1_ready, req0_ready}), (w == 1) ? 32'd2 : 32'd1);
                cur_a = (w == 1) ? a1 : a0;
                cur_b = (w == 1) ? b1 : b0;
                cur_c = (w == 1) ? c1 : c0;
                full  = {1'b0, cur_a} + {1'b0, cur_b} + (W+1)'(cur_c);
                e.id = (w == 1); e.sum = full[W-1:0]; e.cout = full[W]; e.acc_cyc = cyc + 1;
                sb.push_back(e);
                issue_idx = 0;
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Wait for the response to drain; optionally wiggle request valids while the scheduler is busy.
    task automatic wait_done(input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (toggle && i < 15) begin
                req0_valid = 1'($urandom_range(0, 1)); req0_a = 16'($urandom);
                req1_valid = 1'($urandom_range(0, 1)); req1_b = 16'($urandom);
            end else if (toggle && i == 15) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            @(negedge clk);
            if (toggle && i < 15) chk("busy_ready", 32'({req0_ready, req1_ready}), 32'd0);
            if (sb.size() == 0 && !rsp_valid) done = 1'b1;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w, n;
        bit  seen;
        logic [1:0] v;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", 32'({req0_ready, req1_ready, ksa_issue, ksa_a, ksa_b, ksa_cin, rsp_valid, rsp_id, rsp_cout}), 32'd0);
        chk("reset_sum", 32'(rsp_sum), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_reset = 1'b0;

        // T1 (and warm-up length when enabled): carry ripples out of nibble 0.
        accept_req(1, 1'b0, 16'h000F, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, w, n);
        chk("first_accept_wait", 32'(n), 32'(FIRST_WAIT));
        wait_done(0);

        // T2: wrap-around on requester 1.
        accept_req(0, 1, 16'h0, 16'h0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, w, n);
        wait_done(0);
        accept_req(0, 1, 16'h0, 16'h0, 1'b0, 16'h1234, 16'h4321, 1'b1, w, n);
        wait_done(0);

        // T3: both valid together; grants alternate.
        for (int k = 0; k < 4; k++) begin
            accept_req(1, 1, 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), w, n);
            chk("t3_order", 32'(w), 32'(k % 2));
            wait_done(0);
        end

        // T4: five stalled RESP cycles with requests pending; handshake on the sixth.
        stall_next = 5;
        accept_req(1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0, 16'h0, 1'b0, w, n);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("t4_rsp_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_done(0);

        // T5: reset in the WAIT phase of nibble 2 aborts the operation.
        accept_req(1, 1'b0, 16'h5A5A, 16'h0F0F, 1'b1, 16'h0, 16'h0, 1'b0, w, n);
        for (int i = 0; i < 60 && issue_idx < 3; i++) @(negedge clk);
        chk("t5_reached_nib2", 32'(issue_idx), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1; in_reset = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out", 32'({req0_ready, req1_ready, ksa_issue, ksa_a, ksa_b, ksa_cin, rsp_valid, rsp_id, rsp_cout}), 32'd0);
        chk("abort_sum", 32'(rsp_sum), 32'd0);
        sb.delete();
        model_prio = 1'b0;
        issue_idx  = NIBBLES;
        in_reset   = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        accept_req(1, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, w, n);
        wait_done(0);

        // Randomised traffic with random contention, back-pressure and busy-time valid wiggles.
        for (int k = 0; k < 30; k++) begin
            v = 2'($urandom_range(1, 3));
            accept_req(v[0], v[1], 16'($urandom), 16'($urandom), 1'($urandom),
                       16'($urandom), 16'($urandom), 1'($urandom), w, n);
            wait_done(1);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
